// File: rtl/online_negate_sequencer.sv
// Digit-serial operand scheduler: round-robin arbitration between two requesters,
// optional per-digit negation at capture, MSD-first streaming over valid/ready.
module online_negate_sequencer #(
    parameter int no_of_digits = 4,
    parameter int radix_bits   = 3,
    parameter int radix        = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_a,
    input  logic                                 neg_a,
    input  logic [no_of_digits*radix_bits-1:0]   x_a,
    output logic                                 ack_a,
    input  logic                                 req_b,
    input  logic                                 neg_b,
    input  logic [no_of_digits*radix_bits-1:0]   x_b,
    output logic                                 ack_b,
    input  logic                                 abort,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [radix_bits-1:0]                out_digit,
    output logic [((no_of_digits > 1) ? $clog2(no_of_digits) : 1)-1:0] out_idx,
    output logic                                 out_last,
    output logic                                 out_src,
    output logic                                 busy
);

    localparam int IDX_W = (no_of_digits > 1) ? $clog2(no_of_digits) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(no_of_digits - 1);

    // radix only documents the digit set; an illegal value leaves a visible marker
    if (radix < 2) begin : g_radix_unsupported
        logic radix_unsupported;
        assign radix_unsupported = 1'b1;
    end

    typedef enum logic {IDLE, STREAM} state_t;

    state_t state, state_next;

    logic [radix_bits-1:0]              digits [no_of_digits];
    logic                               ptr;
    logic                               any_req;
    logic                               grant;
    logic                               at_lsd;
    logic                               capture;
    logic [no_of_digits*radix_bits-1:0] x_sel;
    logic                               neg_sel;

    always_comb begin
        any_req = req_a | req_b;
        // ptr holds the last grant (1 = B); with both requesting, the other side wins
        grant   = req_b & (~req_a | ~ptr);
        at_lsd  = (out_idx == '0);
        capture = ~abort & any_req &
                  ((state == IDLE) | ((state == STREAM) & out_ready & at_lsd));
        x_sel   = grant ? x_b : x_a;
        neg_sel = grant ? neg_b : neg_a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort)
            state_next = IDLE;
        else if (capture)
            state_next = STREAM;
        else if ((state == STREAM) && out_ready && at_lsd)
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < no_of_digits; i++) digits[i] <= '0;
            out_idx <= '0;
            out_src <= 1'b0;
            ptr     <= 1'b1;
        end else if (abort) begin
            out_idx <= '0;
        end else if (capture) begin
            for (int unsigned i = 0; i < no_of_digits; i++) begin
                if (neg_sel) digits[i] <= '0 - x_sel[i*radix_bits +: radix_bits];
                else         digits[i] <= x_sel[i*radix_bits +: radix_bits];
            end
            out_idx <= LAST_IDX;
            out_src <= grant;
            ptr     <= grant;
        end else if ((state == STREAM) && out_ready && !at_lsd) begin
            out_idx <= out_idx - 1'b1;
        end
    end

    always_comb begin
        busy      = (state == STREAM);
        out_valid = busy;
        out_last  = busy & at_lsd;
        out_digit = busy ? digits[out_idx] : '0;
        ack_a     = capture & ~grant;
        ack_b     = capture & grant;
    end

endmodule

// File: tb/tb_online_negate_sequencer.sv
// Directed bench for online_negate_sequencer with hand-computed digit streams.
module tb_online_negate_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_a, neg_a, ack_a;
    logic        req_b, neg_b, ack_b;
    logic [11:0] x_a, x_b;
    logic        abort;
    logic        out_valid, out_ready, out_last, out_src, busy;
    logic [2:0]  out_digit;
    logic [1:0]  out_idx;

    int tests_run = 0;
    int tests_failed = 0;
    int accepted;
    bit count_en = 1'b0;

    online_negate_sequencer #(
        .no_of_digits(4),
        .radix_bits  (3),
        .radix       (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (req_a),
        .neg_a    (neg_a),
        .x_a      (x_a),
        .ack_a    (ack_a),
        .req_b    (req_b),
        .neg_b    (neg_b),
        .x_b      (x_b),
        .ack_b    (ack_b),
        .abort    (abort),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_digit(out_digit),
        .out_idx  (out_idx),
        .out_last (out_last),
        .out_src  (out_src),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!count_en) accepted = 0;
        else if (out_valid === 1'b1 && out_ready === 1'b1) accepted++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks four digits MSD-first from the current cycle, with no requests pending.
    task automatic stream4(input string tag, input logic [11:0] expw, input logic src);
        logic [2:0] d;
        for (int i = 3; i >= 0; i--) begin
            d = expw[i*3 +: 3];
            chk({tag, " valid"}, 32'(out_valid), 32'd1);
            chk({tag, " digit"}, 32'(out_digit), 32'(d));
            chk({tag, " idx"},   32'(out_idx),   32'(i));
            chk({tag, " last"},  32'(out_last),  32'(i == 0));
            chk({tag, " src"},   32'(out_src),   32'(src));
            chk({tag, " ack"},   32'({ack_a, ack_b}), 32'd0);
            tick();
        end
        chk({tag, " idle valid"}, 32'(out_valid), 32'd0);
        chk({tag, " idle busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_a = 1'b0; neg_a = 1'b0; x_a = '0;
        req_b = 1'b0; neg_b = 1'b0; x_b = '0; abort = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst valid", 32'(out_valid), 32'd0);
        chk("rst digit", 32'(out_digit), 32'd0);
        chk("rst idx",   32'(out_idx),   32'd0);
        chk("rst last",  32'(out_last),  32'd0);
        chk("rst src",   32'(out_src),   32'd0);
        chk("rst busy",  32'(busy),      32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Plain stream of digits 1,-2,3,0; x changes after capture must not matter
        req_a = 1'b1; neg_a = 1'b0; x_a = 12'h398; out_ready = 1'b1;
        #1;
        chk("t1 ack", 32'({ack_a, ack_b}), 32'b10);
        chk("t1 cap valid", 32'(out_valid), 32'd0);
        tick();
        req_a = 1'b0; x_a = 12'hFFF;
        stream4("t1", 12'b001_110_011_000, 1'b0);

        // Negated: -1,2,-3,0
        req_a = 1'b1; neg_a = 1'b1; x_a = 12'h398;
        #1;
        chk("t2 ack", 32'({ack_a, ack_b}), 32'b10);
        tick();
        req_a = 1'b0; neg_a = 1'b0;
        stream4("t2", 12'b111_010_101_000, 1'b0);

        // B alone: most negative digit negates to itself
        req_b = 1'b1; neg_b = 1'b1; x_b = 12'b100_000_000_000;
        #1;
        chk("t2w ack", 32'({ack_a, ack_b}), 32'b01);
        tick();
        req_b = 1'b0; neg_b = 1'b0;
        stream4("t2w", 12'b100_000_000_000, 1'b1);

        // Both requesting: A (last grant was B), then B, A, B with no bubbles
        req_a = 1'b1; req_b = 1'b1; x_a = 12'h398; x_b = 12'h5A3;
        #1;
        chk("t3 first ack", 32'({ack_a, ack_b}), 32'b10);
        tick();
        for (int k = 0; k < 4; k++) begin
            logic [11:0] w;
            logic [2:0]  d;
            w = (k % 2 == 0) ? 12'b001_110_011_000 : 12'b010_110_100_011;
            for (int i = 3; i >= 0; i--) begin
                d = w[i*3 +: 3];
                chk("t3 valid", 32'(out_valid), 32'd1);
                chk("t3 digit", 32'(out_digit), 32'(d));
                chk("t3 idx",   32'(out_idx),   32'(i));
                chk("t3 src",   32'(out_src),   32'(k % 2));
                if (i == 0) chk("t3 lsd ack", 32'({ack_a, ack_b}), (k % 2 == 0) ? 32'b01 : 32'b10);
                else        chk("t3 mid ack", 32'({ack_a, ack_b}), 32'd0);
                tick();
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        stream4("t3 tail", 12'b001_110_011_000, 1'b0);

        // Backpressure on idx 2 for three cycles
        count_en = 1'b1;
        req_a = 1'b1; x_a = 12'h398;
        #1;
        chk("t4 ack", 32'({ack_a, ack_b}), 32'b10);
        tick();
        req_a = 1'b0;
        chk("t4 idx3", 32'(out_idx), 32'd3);
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("t4 hold digit", 32'(out_digit), 32'b110);
            chk("t4 hold idx",   32'(out_idx),   32'd2);
            chk("t4 hold valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        chk("t4 resume digit", 32'(out_digit), 32'b110);
        chk("t4 resume idx",   32'(out_idx),   32'd2);
        tick();
        chk("t4 idx1", 32'(out_idx), 32'd1);
        tick();
        chk("t4 idx0", 32'(out_idx), 32'd0);
        chk("t4 last", 32'(out_last), 32'd1);
        tick();
        chk("t4 idle", 32'(out_valid), 32'd0);
        chk("t4 accepted", 32'(accepted), 32'd4);
        count_en = 1'b0;

        // Abort at idx 1 with B pending; B served after abort drops
        req_a = 1'b1; x_a = 12'h398;
        #1;
        chk("t5 ack", 32'({ack_a, ack_b}), 32'b10);
        tick();
        req_a = 1'b0;
        tick();
        tick();
        abort = 1'b1; req_b = 1'b1; neg_b = 1'b1; x_b = 12'h5A3;
        #1;
        chk("t5 abort idx", 32'(out_idx), 32'd1);
        chk("t5 abort ack", 32'({ack_a, ack_b}), 32'd0);
        tick();
        abort = 1'b0;
        #1;
        chk("t5 post valid", 32'(out_valid), 32'd0);
        chk("t5 post idx",   32'(out_idx),   32'd0);
        chk("t5 post ack",   32'({ack_a, ack_b}), 32'b01);
        tick();
        req_b = 1'b0; neg_b = 1'b0; x_b = '0;
        stream4("t5 b", 12'b110_010_100_101, 1'b1);

        // Asynchronous reset mid-stream, then A has priority again
        req_a = 1'b1; x_a = 12'h398;
        #1;
        chk("t6 ack", 32'({ack_a, ack_b}), 32'b10);
        tick();
        req_a = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t6 rst valid", 32'(out_valid), 32'd0);
        chk("t6 rst busy",  32'(busy),      32'd0);
        chk("t6 rst idx",   32'(out_idx),   32'd0);
        chk("t6 rst digit", 32'(out_digit), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        req_a = 1'b1; req_b = 1'b1; x_b = 12'h5A3;
        #1;
        chk("t6 prio ack", 32'({ack_a, ack_b}), 32'b10);
        tick();
        req_a = 1'b0; req_b = 1'b0;
        stream4("t6", 12'b001_110_011_000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/online_negate_sequencer.md
Name: online_negate_sequencer

Overview:
- Digit-serial operand scheduler for the online-arithmetic datapath.
- Arbitrates two requesters, each presenting a parallel signed-digit operand plus a negate flag.
- Captures the granted operand, applying per-digit negation when requested, into a shift register.
- Streams the operand MSD-first, one digit per cycle, over a valid/ready interface to the online operator.

Parameters:
- no_of_digits, 4, number of digits per operand (≥2)
- radix_bits, 3, width of one two's-complement signed digit
- radix, 4, radix of the digit set; informational only, no logic depends on it
- localparam IDX_W = max(1, ceil(log2(no_of_digits)))

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_a  in  1  requester A has an operand pending
- neg_a  in  1  negate A's operand before streaming
- x_a  in  no_of_digits*radix_bits  A's operand; digit i at [(i+1)*radix_bits-1 : i*radix_bits]; digit no_of_digits-1 is MSD
- ack_a  out  1  A's operand captured this cycle
- req_b, neg_b, x_b, ack_b  same as the A ports, for requester B
- abort  in  1  synchronous flush of the current stream
- out_valid  out  1  out_digit valid
- out_ready  in  1  consumer accepts the digit
- out_digit  out  radix_bits  current digit
- out_idx  out  IDX_W  digit position; no_of_digits-1 down to 0
- out_last  out  1  current digit is the LSD (out_idx==0)
- out_src  out  1  0 = operand from A, 1 = operand from B
- busy  out  1  state is STREAM

Behaviour:
- Async reset values:
  - state=IDLE; out_valid=0, out_digit=0, out_idx=0, out_last=0, out_src=0, busy=0.
  - Shift register cleared; round-robin pointer gives A priority.
- ack_a/ack_b are combinational, asserted only in a capture cycle; they are never both high.
- Capture occurs when either:
  - (state==IDLE and any req), or
  - (state==STREAM, out_valid & out_ready & out_last, and any req) — back-to-back capture.
  - No capture when abort=1.
- Arbitration:
  - Single requester wins.
  - Both requesting: grant the one not granted at the previous capture. The pointer updates only on capture.
- Capture action:
  - Each digit d is stored as (neg ? -d : d) in two's complement, truncated to radix_bits.
  - -(-2^(radix_bits-1)) wraps to itself (3-bit: 100 -> 100). No error flag.
  - out_src=grant; out_idx=no_of_digits-1; state=STREAM.
- STREAM:
  - out_valid=1; out_digit = stored digit at out_idx.
  - out_digit, out_idx and out_src are held stable while out_valid & !out_ready.
- On out_valid & out_ready:
  - If !out_last: out_idx decrements.
  - If out_last: capture if a req is pending (no bubble); otherwise go to IDLE with out_valid=0.
- Latency:
  - A req seen in cycle N in IDLE gives its MSD valid in cycle N+1.
  - With out_ready=1, the LSD is presented in cycle N+no_of_digits.
- abort=1 (any state):
  - Next cycle: state=IDLE, out_valid=0, out_idx=0.
  - No ack that cycle; pending reqs are served after abort deasserts.
  - The round-robin pointer is unchanged.
- req, neg and x are sampled only in the capture cycle. Later changes do not affect the digit stream.
- Reset asserted mid-stream: all outputs return to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset, then req_a=1, neg_a=0, x_a=12'h398 (digits 1,-2,3,0), out_ready=1:
  - ack_a pulses in cycle 0.
  - out_digit=001,110,011,000 in cycles 1-4; out_idx=3,2,1,0; out_last only in cycle 4; out_src=0; idle in cycle 5.
- Same operand with neg_a=1:
  - Stream 111,010,101,000.
  - Separately, digit 100 negated streams as 100 (wrap).
- req_a and req_b both held high, out_ready=1:
  - Grants alternate A,B,A,B.
  - Each new capture (ack) coincides with the LSD handshake; no idle cycle between operands.
  - out_src toggles.
- Backpressure: out_ready=0 for 3 cycles on digit idx 2:
  - out_digit and out_idx are held stable.
  - Stream resumes when out_ready=1; exactly 4 digits are accepted in total.
- abort asserted at idx 1 while req_b is pending:
  - out_valid=0 next cycle; no ack during abort.
  - B is captured the cycle after abort drops; its MSD appears one cycle later.
- rst_n pulsed low mid-stream:
  - out_valid and busy drop immediately (asynchronously).
  - After release, A has priority when both requesters are asserted.
